// File: rtl/display_capture_if.sv
// Seven-segment bus plus decoded readback, bundled for display_capture.
// master: drives scan/disp (display side or bench) and observes the readback.
// slave: the capture block itself, which samples scan/disp and drives the rest.
interface display_capture_if;
  logic [3:0] scan;     // digit select, active-low one-hot
  logic [6:0] disp;     // segments {g,f,e,d,c,b,a}, active-low
  logic [3:0] dig0;     // last decoded value, digit 0
  logic [3:0] dig1;     // last decoded value, digit 1
  logic [3:0] dig2;     // last decoded value, digit 2
  logic [3:0] dig3;     // last decoded value, digit 3
  logic [3:0] valid;    // per-digit fresh-and-legal flag
  logic       upd;      // one-cycle strobe per legal capture
  logic [1:0] upd_idx;  // digit index qualified by upd
  logic       seg_err;  // one-cycle strobe per illegal settled pattern

  modport master (
    output scan, disp,
    input  dig0, dig1, dig2, dig3, valid, upd, upd_idx, seg_err
  );

  modport slave (
    input  scan, disp,
    output dig0, dig1, dig2, dig3, valid, upd, upd_idx, seg_err
  );
endinterface

// File: rtl/display_capture.sv
// Purpose: passive decoder of a muxed 4-digit 7-seg bus back to per-digit hex with valid/stale tracking.
// Latency: a pair first sampled at edge E1 and held is captured at edge E(STABLE_CYCLES+1); outputs registered.
// Backpressure: none; monitor only, never stalls the observed bus.
// Ports: clk, rst_n (sync, active-low); bus.slave carries scan/disp in and dig0..3, valid, upd, upd_idx, seg_err out.
module display_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  display_capture_if.slave   bus
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int AW = $clog2(TIMEOUT + 1);

  logic [3:0]          scan_q, scan_d;
  logic [6:0]          disp_q, disp_d;
  logic [SW-1:0]       stab_q, stab_d;
  logic                done_q, done_d;
  logic [3:0][3:0]     dig_q, dig_d;
  logic [3:0]          valid_q, valid_d;
  logic                upd_q, upd_d;
  logic [1:0]          upd_idx_q, upd_idx_d;
  logic                seg_err_q, seg_err_d;
  logic [3:0][AW-1:0]  age_q, age_d;

  logic                changed;
  logic                sel_ok;
  logic [1:0]          sel_idx;
  logic                capture;
  logic [4:0]          dec;      // {legal, value}

  // Active-low segment pattern to {legal, hex value}; anything else (blank included) is illegal.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40:   return 5'h10;
      7'h79:   return 5'h11;
      7'h24:   return 5'h12;
      7'h30:   return 5'h13;
      7'h19:   return 5'h14;
      7'h12:   return 5'h15;
      7'h02:   return 5'h16;
      7'h78:   return 5'h17;
      7'h00:   return 5'h18;
      7'h10:   return 5'h19;
      7'h08:   return 5'h1A;
      7'h03:   return 5'h1B;
      7'h46:   return 5'h1C;
      7'h21:   return 5'h1D;
      7'h06:   return 5'h1E;
      7'h0E:   return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  always_comb begin
    scan_d    = bus.scan;
    disp_d    = bus.disp;
    dig_d     = dig_q;
    valid_d   = valid_q;
    age_d     = age_q;
    upd_d     = 1'b0;
    seg_err_d = 1'b0;
    upd_idx_d = upd_idx_q;

    changed = (bus.scan != scan_q) || (bus.disp != disp_q);

    if (changed)
      stab_d = SW'(1);
    else if (stab_q != SW'(STABLE_CYCLES))
      stab_d = stab_q + SW'(1);
    else
      stab_d = stab_q;

    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (scan_q)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase

    dec = seg_decode(disp_q);

    // Requiring the incoming pair to still match means a phase must be
    // sampled on STABLE_CYCLES+1 consecutive edges to count; shorter
    // phases (switching glitches, ghosting) are dropped.
    capture = !changed && (stab_q == SW'(STABLE_CYCLES)) && !done_q && sel_ok;

    if (changed)
      done_d = 1'b0;
    else if (capture)
      done_d = 1'b1;
    else
      done_d = done_q;

    for (int n = 0; n < 4; n++) begin
      if (age_q[n] != AW'(TIMEOUT))
        age_d[n] = age_q[n] + AW'(1);
      if (age_d[n] == AW'(TIMEOUT))
        valid_d[n] = 1'b0;
    end

    // Applied after the age update so a capture on the timeout edge wins.
    if (capture) begin
      if (dec[4]) begin
        dig_d[sel_idx]   = dec[3:0];
        valid_d[sel_idx] = 1'b1;
        age_d[sel_idx]   = '0;
        upd_d            = 1'b1;
        upd_idx_d        = sel_idx;
      end else begin
        valid_d[sel_idx] = 1'b0;
        seg_err_d        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q    <= 4'hF;
      disp_q    <= 7'h7F;
      stab_q    <= '0;
      done_q    <= 1'b0;
      dig_q     <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= 2'd0;
      seg_err_q <= 1'b0;
      age_q     <= '0;
    end else begin
      scan_q    <= scan_d;
      disp_q    <= disp_d;
      stab_q    <= stab_d;
      done_q    <= done_d;
      dig_q     <= dig_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      seg_err_q <= seg_err_d;
      age_q     <= age_d;
    end
  end

  assign bus.dig0    = dig_q[0];
  assign bus.dig1    = dig_q[1];
  assign bus.dig2    = dig_q[2];
  assign bus.dig3    = dig_q[3];
  assign bus.valid   = valid_q;
  assign bus.upd     = upd_q;
  assign bus.upd_idx = upd_idx_q;
  assign bus.seg_err = seg_err_q;

endmodule
